// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller.
// Holds cause codes, CSR addresses, CSR bit positions and the one-hot FSM encoding.
// Also holds the trap vector helper used when the trap target is latched.
package trap_pkg;

  // One-hot controller states
  localparam logic [5:0] S_IDLE      = 6'b000001;
  localparam logic [5:0] S_W_MEPC    = 6'b000010;
  localparam logic [5:0] S_W_MTVAL   = 6'b000100;
  localparam logic [5:0] S_W_MSTATUS = 6'b001000;
  localparam logic [5:0] S_ASSERT    = 6'b010000;
  localparam logic [5:0] S_MRET      = 6'b100000;

  // CSR addresses written by the sequencer
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MTVAL   = 32'h0000_0343;
  localparam logic [31:0] CSR_DPC     = 32'h0000_07B1;

  // Exception cause codes
  localparam logic [31:0] EXC_INST_MISA  = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL    = 32'd2;
  localparam logic [31:0] EXC_BREAK      = 32'd3;
  localparam logic [31:0] EXC_LOAD_MISA  = 32'd4;
  localparam logic [31:0] EXC_STORE_MISA = 32'd6;
  localparam logic [31:0] EXC_ECALL_M    = 32'd11;

  // Interrupt cause codes (bit31 is added by the arbiter)
  localparam logic [31:0] IRQ_SW        = 32'd3;
  localparam logic [31:0] IRQ_TIMER     = 32'd7;
  localparam logic [31:0] IRQ_EXT       = 32'd11;
  localparam logic [31:0] IRQ_FAST_BASE = 32'd16;

  // CSR bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIE_FAST0    = 16;
  localparam int DCSR_EBREAKM = 15;

  // Vectored mode only offsets interrupts; anything but mode 1 is direct
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic is_irq,
                                              input logic [4:0] code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_irq) return base + {25'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Execute-stage trap bus: instruction/exception info in, CSR write and redirect out.
// No latency of its own; pure signal bundle.
// No backpressure; the controller holds the pipeline through its stall flag.
interface trap_ctrl_if;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic [31:0] mem_addr_i;
  logic        inst_illegal_i;
  logic        inst_addr_misa_i;
  logic        load_misa_i;
  logic        store_misa_i;
  logic        inst_ecall_i;
  logic        inst_ebreak_i;
  logic        inst_mret_i;
  logic        inst_dret_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  modport master (
    output inst_valid_i, inst_addr_i, inst_i, mem_addr_i, inst_illegal_i,
           inst_addr_misa_i, load_misa_i, store_misa_i, inst_ecall_i,
           inst_ebreak_i, inst_mret_i, inst_dret_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
  );

  modport slave (
    input  inst_valid_i, inst_addr_i, inst_i, mem_addr_i, inst_illegal_i,
           inst_addr_misa_i, load_misa_i, store_misa_i, inst_ecall_i,
           inst_ebreak_i, inst_mret_i, inst_dret_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/trap_irq_arb.sv
// Interrupt priority encoder: fast (lowest index) > external > software > timer.
// Purely combinational, zero latency.
// No backpressure; sources are level and stay pending until serviced.
module trap_irq_arb
  import trap_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 15
) (
  input  logic                    en,
  input  logic                    irq_software,
  input  logic                    irq_timer,
  input  logic                    irq_external,
  input  logic [NUM_FAST_IRQ-1:0] irq_fast,
  input  logic [31:0]             mie,
  output logic                    req,
  output logic [31:0]             cause
);

  // Only the enable bits of implemented sources matter
  logic unused_mie;
  assign unused_mie = ^mie;

  // Later assignments override earlier ones, so lowest priority goes first
  always_comb begin
    req   = 1'b0;
    cause = '0;
    if (irq_timer & mie[MIE_MTIE]) begin
      req   = 1'b1;
      cause = IRQ_TIMER;
    end
    if (irq_software & mie[MIE_MSIE]) begin
      req   = 1'b1;
      cause = IRQ_SW;
    end
    if (irq_external & mie[MIE_MEIE]) begin
      req   = 1'b1;
      cause = IRQ_EXT;
    end
    for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
      if (irq_fast[i] & mie[MIE_FAST0 + i]) begin
        req   = 1'b1;
        cause = IRQ_FAST_BASE + 32'(i);
      end
    end
    req       = req & en;
    cause[31] = req;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions/debug/interrupts/mret/dret, sequences CSR writes, redirects fetch.
// Trap entry: mcause in request cycle, int_assert 4 cycles later (3 without mtval); mret 2 cycles; debug/dret 1 cycle.
// Holds the pipeline via stall_flag_o; requests arriving outside S_IDLE are ignored and must be held by the source.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 15,
  parameter bit MTVAL_EN     = 1'b1,
  parameter bit DEBUG_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  trap_ctrl_if.slave              bus,
  input  logic [31:0]             mtvec_i,
  input  logic [31:0]             mepc_i,
  input  logic [31:0]             mstatus_i,
  input  logic [31:0]             mie_i,
  input  logic [31:0]             dpc_i,
  input  logic [31:0]             dcsr_i,
  input  logic                    irq_software_i,
  input  logic                    irq_timer_i,
  input  logic                    irq_external_i,
  input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
  input  logic [31:0]             debug_halt_addr_i,
  input  logic                    debug_req_i,
  output logic                    stall_flag_o,
  output logic                    debug_mode_o
);

  logic [5:0]  state_q;
  logic [31:0] target_q, epc_q, tval_q;
  logic        debug_mode_q;

  logic        exc_req, irq_req, dbg_req, dbg_ebreak, mret_req, dret_req;
  logic        take_trap, any_req;
  logic [31:0] exc_cause, exc_tval, irq_cause, trap_cause, trap_tval;
  logic        csr_we;
  logic [31:0] csr_waddr, csr_wdata;

  logic unused_dcsr;
  assign unused_dcsr = ^dcsr_i;

  trap_irq_arb #(.NUM_FAST_IRQ(NUM_FAST_IRQ)) u_irq_arb (
    .en           (bus.inst_valid_i & mstatus_i[MSTATUS_MIE] & ~debug_mode_q),
    .irq_software (irq_software_i),
    .irq_timer    (irq_timer_i),
    .irq_external (irq_external_i),
    .irq_fast     (irq_fast_i),
    .mie          (mie_i),
    .req          (irq_req),
    .cause        (irq_cause)
  );

  assign dbg_ebreak = DEBUG_EN & bus.inst_valid_i & bus.inst_ebreak_i & dcsr_i[DCSR_EBREAKM];
  assign dbg_req    = dbg_ebreak | (DEBUG_EN & debug_req_i & ~debug_mode_q);
  assign mret_req   = bus.inst_valid_i & bus.inst_mret_i;
  assign dret_req   = bus.inst_valid_i & bus.inst_dret_i;
  assign take_trap  = exc_req | (irq_req & ~dbg_req);
  assign any_req    = exc_req | dbg_req | irq_req | mret_req | dret_req;
  assign trap_cause = exc_req ? exc_cause : irq_cause;
  assign trap_tval  = exc_req ? exc_tval : 32'd0;

  // Synchronous exception priority encoder with the matching mtval
  always_comb begin
    exc_req   = 1'b0;
    exc_cause = '0;
    exc_tval  = '0;
    if (bus.inst_valid_i) begin
      if (bus.inst_addr_misa_i) begin
        exc_req = 1'b1; exc_cause = EXC_INST_MISA; exc_tval = bus.inst_addr_i;
      end else if (bus.inst_illegal_i) begin
        exc_req = 1'b1; exc_cause = EXC_ILLEGAL; exc_tval = bus.inst_i;
      end else if (bus.inst_ebreak_i && !(DEBUG_EN && dcsr_i[DCSR_EBREAKM])) begin
        exc_req = 1'b1; exc_cause = EXC_BREAK; exc_tval = bus.inst_addr_i;
      end else if (bus.load_misa_i) begin
        exc_req = 1'b1; exc_cause = EXC_LOAD_MISA; exc_tval = bus.mem_addr_i;
      end else if (bus.store_misa_i) begin
        exc_req = 1'b1; exc_cause = EXC_STORE_MISA; exc_tval = bus.mem_addr_i;
      end else if (bus.inst_ecall_i) begin
        exc_req = 1'b1; exc_cause = EXC_ECALL_M; exc_tval = '0;
      end
    end
  end

  // Sequencer: arbitrate in S_IDLE and latch everything later states need
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      epc_q        <= '0;
      tval_q       <= '0;
      debug_mode_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_trap) begin
            target_q <= trap_target(mtvec_i, ~exc_req, trap_cause[4:0]);
            epc_q    <= bus.inst_addr_i;
            tval_q   <= trap_tval;
            state_q  <= S_W_MEPC;
          end else if (dbg_req) begin
            target_q     <= debug_halt_addr_i;
            debug_mode_q <= 1'b1;
            state_q      <= S_ASSERT;
          end else if (mret_req) begin
            target_q <= mepc_i;
            state_q  <= S_MRET;
          end else if (dret_req) begin
            target_q     <= dpc_i;
            debug_mode_q <= 1'b0;
            state_q      <= S_ASSERT;
          end
        end
        S_W_MEPC:    state_q <= MTVAL_EN ? S_W_MTVAL : S_W_MSTATUS;
        S_W_MTVAL:   state_q <= S_W_MSTATUS;
        S_W_MSTATUS: state_q <= S_ASSERT;
        S_MRET:      state_q <= S_ASSERT;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  // CSR write port: one write per cycle, chosen by state (and request in S_IDLE)
  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          csr_we = 1'b1; csr_waddr = CSR_MCAUSE; csr_wdata = trap_cause;
        end else if (dbg_req && !dbg_ebreak) begin
          csr_we = 1'b1; csr_waddr = CSR_DPC; csr_wdata = bus.inst_addr_i;
        end
      end
      S_W_MEPC: begin
        csr_we = 1'b1; csr_waddr = CSR_MEPC; csr_wdata = epc_q;
      end
      S_W_MTVAL: begin
        csr_we = 1'b1; csr_waddr = CSR_MTVAL; csr_wdata = tval_q;
      end
      S_W_MSTATUS: begin
        csr_we = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = mstatus_i;
        csr_wdata[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        csr_wdata[MSTATUS_MIE]  = 1'b0;
      end
      S_MRET: begin
        csr_we = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = mstatus_i;
        csr_wdata[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        csr_wdata[MSTATUS_MPIE] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.csr_we_o     = csr_we;
  assign bus.csr_waddr_o  = csr_waddr;
  assign bus.csr_wdata_o  = csr_wdata;
  assign bus.int_assert_o = (state_q == S_ASSERT);
  assign bus.int_addr_o   = target_q;
  assign stall_flag_o     = ((state_q != S_IDLE) && (state_q != S_ASSERT)) ||
                            ((state_q == S_IDLE) && any_req);
  assign debug_mode_o     = DEBUG_EN & debug_mode_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed requests push expected CSR writes/redirects with their cycle.
// A negedge monitor pops and compares every CSR write and redirect pulse from both instances.
// Second instance uses NUM_FAST_IRQ=4 and MTVAL_EN=0.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  trap_ctrl_if bus ();
  trap_ctrl_if bus4 ();

  logic [31:0] mtvec, mepc, mstatus, mie, dpc, dcsr, halt;
  logic        sw, tim, ext, dbg_req;
  logic [14:0] fast;
  logic        stall, dmode, stall4, dmode4;

  trap_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus), .mie_i(mie),
    .dpc_i(dpc), .dcsr_i(dcsr),
    .irq_software_i(sw), .irq_timer_i(tim), .irq_external_i(ext), .irq_fast_i(fast),
    .debug_halt_addr_i(halt), .debug_req_i(dbg_req),
    .stall_flag_o(stall), .debug_mode_o(dmode)
  );

  trap_ctrl #(.NUM_FAST_IRQ(4), .MTVAL_EN(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus), .mie_i(mie),
    .dpc_i(dpc), .dcsr_i(dcsr),
    .irq_software_i(sw), .irq_timer_i(tim), .irq_external_i(ext), .irq_fast_i(fast[3:0]),
    .debug_halt_addr_i(halt), .debug_req_i(1'b0),
    .stall_flag_o(stall4), .debug_mode_o(dmode4)
  );

  typedef struct {
    int          d;
    bit          redir;
    logic [31:0] a;
    logic [31:0] v;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   k;

  task automatic push(input int d, input bit r, input logic [31:0] a, input logic [31:0] v, input int c);
    exp_t e;
    e.d = d; e.redir = r; e.a = a; e.v = v; e.c = c;
    q.push_back(e);
  endtask

  // Full trap entry: mcause, mepc, [mtval], mstatus, redirect
  task automatic exp_trap(input int d, input int kk, input logic [31:0] cause, input logic [31:0] epc,
                          input logic [31:0] tval, input logic [31:0] mst, input logic [31:0] tgt,
                          input bit has_tval);
    push(d, 1'b0, 32'h342, cause, kk);
    push(d, 1'b0, 32'h341, epc, kk + 1);
    if (has_tval) begin
      push(d, 1'b0, 32'h343, tval, kk + 2);
      kk = kk + 1;
    end
    push(d, 1'b0, 32'h300, mst, kk + 2);
    push(d, 1'b1, tgt, 32'h0, kk + 3);
  endtask

  task automatic sb_check(input int d, input bit r, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got dut%0d redir=%0d addr=%h data=%h cyc=%0d, required no event",
               d, r, a, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.d != d || e.redir != r || e.a !== a || (!r && e.v !== v) || e.c != cyc) begin
        n_err++;
        $display("FAIL sb_event: got dut%0d redir=%0d addr=%h data=%h cyc=%0d, required dut%0d redir=%0d addr=%h data=%h cyc=%0d",
                 d, r, a, v, cyc, e.d, e.redir, e.a, e.v, e.c);
      end
    end
  endtask

  // Monitor: every CSR write and redirect pulse is checked against the scoreboard
  always @(negedge clk) begin
    if (bus.csr_we_o)      sb_check(0, 1'b0, bus.csr_waddr_o, bus.csr_wdata_o);
    if (bus.int_assert_o)  sb_check(0, 1'b1, bus.int_addr_o, 32'h0);
    if (bus4.csr_we_o)     sb_check(1, 1'b0, bus4.csr_waddr_o, bus4.csr_wdata_o);
    if (bus4.int_assert_o) sb_check(1, 1'b1, bus4.int_addr_o, 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic clear_instr();
    bus.inst_valid_i = 0; bus.inst_illegal_i = 0; bus.inst_addr_misa_i = 0;
    bus.load_misa_i = 0; bus.store_misa_i = 0; bus.inst_ecall_i = 0;
    bus.inst_ebreak_i = 0; bus.inst_mret_i = 0; bus.inst_dret_i = 0;
    bus4.inst_valid_i = 0; bus4.inst_illegal_i = 0; bus4.inst_addr_misa_i = 0;
    bus4.load_misa_i = 0; bus4.store_misa_i = 0; bus4.inst_ecall_i = 0;
    bus4.inst_ebreak_i = 0; bus4.inst_mret_i = 0; bus4.inst_dret_i = 0;
    sw = 0; tim = 0; ext = 0; fast = '0; dbg_req = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request cycle: stall must be raised, then all one-shot inputs drop
  task automatic fire(input bit d);
    @(negedge clk);
    if (d) chk("stall4_req", {31'd0, stall4}, 32'd1);
    else   chk("stall_req", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    clear_instr();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    clear_instr();
    bus.inst_addr_i = 0; bus.inst_i = 0; bus.mem_addr_i = 0;
    bus4.inst_addr_i = 0; bus4.inst_i = 0; bus4.mem_addr_i = 0;
    mtvec = 32'h100; mepc = 0; mstatus = 0; mie = 0; dpc = 0; dcsr = 0; halt = 32'h800;
    wait_cyc(2);
    chk("rst_csr_we", {31'd0, bus.csr_we_o}, 32'd0);
    chk("rst_int_assert", {31'd0, bus.int_assert_o}, 32'd0);
    chk("rst_int_addr", bus.int_addr_o, 32'h0);
    chk("rst_debug_mode", {31'd0, dmode}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // External IRQ, direct mode
    mstatus = 32'h8; mie = 32'h800; mtvec = 32'h100;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1000; ext = 1;
    k = cyc; exp_trap(0, k, 32'h8000000B, 32'h1000, 32'h0, 32'h80, 32'h100, 1'b1);
    fire(0);
    @(negedge clk); chk("stall_busy", {31'd0, stall}, 32'd1);
    wait_cyc(6);

    // External IRQ, vectored mode
    mtvec = 32'h101;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1040; ext = 1;
    k = cyc; exp_trap(0, k, 32'h8000000B, 32'h1040, 32'h0, 32'h80, 32'h12C, 1'b1);
    fire(0); wait_cyc(6);

    // ecall in vectored mode uses the base
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1100; bus.inst_ecall_i = 1;
    k = cyc; exp_trap(0, k, 32'd11, 32'h1100, 32'h0, 32'h80, 32'h100, 1'b1);
    fire(0); wait_cyc(6);

    // Fast lines 3 and 7: lowest index wins, vectored offset 19*4
    mie = 32'h0088_0000;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1180; fast = 15'h0088;
    k = cyc; exp_trap(0, k, 32'h80000013, 32'h1180, 32'h0, 32'h80, 32'h14C, 1'b1);
    fire(0); wait_cyc(6);

    // Illegal beats a coincident timer IRQ
    mie = 32'h80;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1200; bus.inst_i = 32'hFFFF_FFFF;
    bus.inst_illegal_i = 1; tim = 1;
    k = cyc; exp_trap(0, k, 32'd2, 32'h1200, 32'hFFFF_FFFF, 32'h80, 32'h100, 1'b1);
    fire(0); wait_cyc(6);

    // Load misaligned, direct mode
    mtvec = 32'h100; mie = 32'h0;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1300; bus.mem_addr_i = 32'h2003; bus.load_misa_i = 1;
    k = cyc; exp_trap(0, k, 32'd4, 32'h1300, 32'h2003, 32'h80, 32'h100, 1'b1);
    fire(0); wait_cyc(6);

    // Instruction misaligned beats store misaligned
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1302; bus.mem_addr_i = 32'h2005;
    bus.inst_addr_misa_i = 1; bus.store_misa_i = 1;
    k = cyc; exp_trap(0, k, 32'd0, 32'h1302, 32'h1302, 32'h80, 32'h100, 1'b1);
    fire(0); wait_cyc(6);

    // ebreak without dcsr.ebreakm is a breakpoint exception
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1500; bus.inst_ebreak_i = 1;
    k = cyc; exp_trap(0, k, 32'd3, 32'h1500, 32'h1500, 32'h80, 32'h100, 1'b1);
    fire(0); wait_cyc(6);

    // mret: MIE restored from MPIE, MPIE set
    mstatus = 32'h80; mepc = 32'h2000;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1600; bus.inst_mret_i = 1;
    k = cyc;
    push(0, 1'b0, 32'h300, 32'h88, k + 1);
    push(0, 1'b1, 32'h2000, 32'h0, k + 2);
    fire(0); wait_cyc(4);
    mstatus = 32'h8;

    // Debug request held during a trap is taken once back in S_IDLE
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1400; bus.inst_ecall_i = 1;
    k = cyc; exp_trap(0, k, 32'd11, 32'h1400, 32'h0, 32'h80, 32'h100, 1'b1);
    push(0, 1'b0, 32'h7B1, 32'h1404, k + 5);
    push(0, 1'b1, 32'h800, 32'h0, k + 6);
    fire(0);
    dbg_req = 1; bus.inst_addr_i = 32'h1404;
    wait_cyc(4);
    wait_cyc(1);
    dbg_req = 0;
    wait_cyc(3);
    chk("debug_mode_set", {31'd0, dmode}, 32'd1);

    // dret leaves debug mode
    dpc = 32'h3000;
    bus.inst_valid_i = 1; bus.inst_dret_i = 1;
    k = cyc; push(0, 1'b1, 32'h3000, 32'h0, k + 1);
    fire(0); wait_cyc(3);
    chk("debug_mode_clr", {31'd0, dmode}, 32'd0);

    // ebreak with dcsr.ebreakm enters debug without a dpc write
    dcsr = 32'h8000;
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1700; bus.inst_ebreak_i = 1;
    k = cyc; push(0, 1'b1, 32'h800, 32'h0, k + 1);
    fire(0); wait_cyc(3);
    chk("debug_mode_ebreak", {31'd0, dmode}, 32'd1);
    dcsr = 32'h0; dpc = 32'h3100;
    bus.inst_valid_i = 1; bus.inst_dret_i = 1;
    k = cyc; push(0, 1'b1, 32'h3100, 32'h0, k + 1);
    fire(0); wait_cyc(3);

    // Four fast lines, no mtval state: only line 3 visible
    mie = 32'h0088_0000; mtvec = 32'h100;
    bus4.inst_valid_i = 1; bus4.inst_addr_i = 32'h4000; fast = 15'h0088;
    k = cyc; exp_trap(1, k, 32'h80000013, 32'h4000, 32'h0, 32'h80, 32'h100, 1'b0);
    fire(1); wait_cyc(6);
    mie = 32'h0;

    // Reset in S_W_MEPC kills the remaining writes at once
    bus.inst_valid_i = 1; bus.inst_addr_i = 32'h1800; bus.inst_ecall_i = 1;
    k = cyc; push(0, 1'b0, 32'h342, 32'd11, k);
    fire(0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_csr_we", {31'd0, bus.csr_we_o}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_int_assert", {31'd0, bus.int_assert_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cyc(6);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL sb_missing: got no event, required dut%0d redir=%0d addr=%h data=%h cyc=%0d",
               e.d, e.redir, e.a, e.v, e.c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
